// File: rtl/reg_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_sched
//  Description : Write-back scheduler and register scoreboard. Arbitrates an
//                ALU requester (A) and a load/memory requester (B) onto the
//                single register-file write port, and tracks reserved
//                destination registers so issue logic can see RAW/WAW hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  // Requester A (ALU)
  input  logic                   a_valid,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [DATA_W-1:0]      a_data,
  output logic                   a_ready,
  // Requester B (load/memory)
  input  logic                   b_valid,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [DATA_W-1:0]      b_data,
  output logic                   b_ready,
  // Register file write port
  output logic                   w_en,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  // Reservation from issue
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  output logic                   set_ok,
  // Hazard queries
  input  logic [ADDR_W-1:0]      rn_addr,
  input  logic [ADDR_W-1:0]      rm_addr,
  output logic                   rn_busy,
  output logic                   rm_busy,
  output logic [(2**ADDR_W)-1:0] busy_vec,
  output logic                   wb_err
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [NREG-1:0] C_ONE = {{(NREG-1){1'b0}}, 1'b1};

  // Round-robin pointer: 0 favours A, 1 favours B
  logic              r_ptr_b;
  logic              r_w_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic [NREG-1:0]   r_busy;
  logic              r_wb_err;

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_grant;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_data;
  logic              w_commit_hit;
  logic              w_set_ok;
  logic [NREG-1:0]   w_clr_mask;
  logic [NREG-1:0]   w_set_mask;

  // Grant: a lone requester wins; a tie goes to the pointer side. Held off in reset.
  always_comb begin
    w_grant_a  = ~rst & a_valid & (~b_valid | ~r_ptr_b);
    w_grant_b  = ~rst & b_valid & (~a_valid |  r_ptr_b);
    w_grant    = w_grant_a | w_grant_b;
    w_gnt_addr = w_grant_b ? b_addr : a_addr;
    w_gnt_data = w_grant_b ? b_data : a_data;
  end

  // Reservation is refused while the register is pending, unless that same
  // register commits this cycle (the old write retires as the new one reserves).
  always_comb begin
    w_commit_hit = r_w_en & (r_rd_addr == set_addr);
    w_set_ok     = set_en & (~r_busy[set_addr] | w_commit_hit);
    w_clr_mask   = r_w_en   ? (C_ONE << r_rd_addr) : '0;
    w_set_mask   = w_set_ok ? (C_ONE << set_addr)  : '0;
  end

  // Pointer flips to the other side after every grant, holds when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr_b <= 1'b0;
    end else if (w_grant) begin
      r_ptr_b <= w_grant_a;
    end
  end

  // Registered write port: one-cycle latency, address/data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_en    <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      r_w_en <= w_grant;
      if (w_grant) begin
        r_rd_addr <= w_gnt_addr;
        r_rd_data <= w_gnt_data;
      end
    end
  end

  // Scoreboard: commit clears, reservation sets (set wins on the same bit);
  // a commit to an unreserved register raises the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= '0;
      r_wb_err <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
      if (r_w_en && !r_busy[r_rd_addr]) begin
        r_wb_err <= 1'b1;
      end
    end
  end

  assign a_ready  = w_grant_a;
  assign b_ready  = w_grant_b;
  assign w_en     = r_w_en;
  assign rd_addr  = r_rd_addr;
  assign rd_data  = r_rd_data;
  assign set_ok   = w_set_ok;
  assign busy_vec = r_busy;
  assign rn_busy  = r_busy[rn_addr];
  assign rm_busy  = r_busy[rm_addr];
  assign wb_err   = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_wb_sched
//  Description : Directed self-checking bench for reg_wb_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_sched;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [3:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [3:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        w_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        set_en;
  logic [3:0]  set_addr;
  logic        set_ok;
  logic [3:0]  rn_addr;
  logic [3:0]  rm_addr;
  logic        rn_busy;
  logic        rm_busy;
  logic [15:0] busy_vec;
  logic        wb_err;

  int n_vec;
  int n_err;

  reg_wb_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .w_en     (w_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .set_en   (set_en),
    .set_addr (set_addr),
    .set_ok   (set_ok),
    .rn_addr  (rn_addr),
    .rm_addr  (rm_addr),
    .rn_busy  (rn_busy),
    .rm_busy  (rm_busy),
    .busy_vec (busy_vec),
    .wb_err   (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    set_en = 0; set_addr = 0; rn_addr = 0; rm_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic reserve(input logic [3:0] r);
    set_en = 1; set_addr = r;
    #1;
    n_vec++;
    if (set_ok !== 1'b1) begin
      n_err++; $display("FAIL reserve_ok r%0d: got %b want 1", r, set_ok);
    end
    tick();
    set_en = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    a_valid = 1; b_valid = 1; a_addr = 3; b_addr = 4;
    #1;
    n_vec++;
    if ({a_ready, b_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b want 00", {a_ready, b_ready});
    end
    tick();
    tick();
    idle_inputs();
    rst = 0;
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if ({w_en, rd_addr, rd_data, busy_vec, wb_err} !== '0) begin
      n_err++;
      $display("FAIL reset_state: w_en=%b rd_addr=%h rd_data=%h busy=%h err=%b want all 0",
               w_en, rd_addr, rd_data, busy_vec, wb_err);
    end
    n_vec++;
    if ({a_ready, b_ready} !== 2'b00) begin
      n_err++; $display("FAIL idle_ready: got %b want 00", {a_ready, b_ready});
    end
  endtask

  task automatic test_single();
    reserve(4'd5);
    n_vec++;
    if (busy_vec !== 16'h0020) begin
      n_err++; $display("FAIL single_busy: got %h want 0020", busy_vec);
    end
    rn_addr = 5; rm_addr = 6;
    #1;
    n_vec++;
    if ({rn_busy, rm_busy} !== 2'b10) begin
      n_err++; $display("FAIL single_query: got %b want 10", {rn_busy, rm_busy});
    end
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    #1;
    n_vec++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_err++; $display("FAIL single_ready: got %b want 10", {a_ready, b_ready});
    end
    tick();
    a_valid = 0;
    n_vec++;
    if ({w_en, rd_addr, rd_data} !== {1'b1, 4'd5, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL single_write: w_en=%b rd_addr=%0d rd_data=%h want 1/5/deadbeef",
                        w_en, rd_addr, rd_data);
    end
    n_vec++;
    if (rn_busy !== 1'b1) begin
      n_err++; $display("FAIL single_busy_until_commit: got %b want 1", rn_busy);
    end
    tick();
    n_vec++;
    if ({busy_vec, wb_err, w_en} !== {16'h0000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL single_commit: busy=%h err=%b w_en=%b want 0000/0/0",
                        busy_vec, wb_err, w_en);
    end
    n_vec++;
    if ({rd_addr, rd_data, rn_busy} !== {4'd5, 32'hDEADBEEF, 1'b0}) begin
      n_err++; $display("FAIL single_hold: rd_addr=%0d rd_data=%h rn_busy=%b want 5/deadbeef/0",
                        rd_addr, rd_data, rn_busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int r = 1; r <= 4; r++) reserve(4'(r));
    n_vec++;
    if (busy_vec !== 16'h001E) begin
      n_err++; $display("FAIL b2b_reserved: got %h want 001e", busy_vec);
    end
    a_valid = 1; a_addr = 1; a_data = 32'hA1;
    b_valid = 1; b_addr = 2; b_data = 32'hB2;
    #1;
    n_vec++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_err++; $display("FAIL b2b_grant0: got %b want 10", {a_ready, b_ready});
    end
    tick();
    a_addr = 3; a_data = 32'hA3;
    #1;
    n_vec++;
    if ({a_ready, b_ready, w_en, rd_addr, rd_data} !== {2'b01, 1'b1, 4'd1, 32'hA1}) begin
      n_err++; $display("FAIL b2b_cycle1: rdy=%b w_en=%b rd_addr=%0d rd_data=%h want 01/1/1/a1",
                        {a_ready, b_ready}, w_en, rd_addr, rd_data);
    end
    tick();
    b_addr = 4; b_data = 32'hB4;
    #1;
    n_vec++;
    if ({a_ready, b_ready, w_en, rd_addr, rd_data, busy_vec} !==
        {2'b10, 1'b1, 4'd2, 32'hB2, 16'h001C}) begin
      n_err++; $display("FAIL b2b_cycle2: rdy=%b w_en=%b rd_addr=%0d rd_data=%h busy=%h want 10/1/2/b2/001c",
                        {a_ready, b_ready}, w_en, rd_addr, rd_data, busy_vec);
    end
    tick();
    a_valid = 0;
    #1;
    n_vec++;
    if ({a_ready, b_ready, w_en, rd_addr, rd_data} !== {2'b01, 1'b1, 4'd3, 32'hA3}) begin
      n_err++; $display("FAIL b2b_cycle3: rdy=%b w_en=%b rd_addr=%0d rd_data=%h want 01/1/3/a3",
                        {a_ready, b_ready}, w_en, rd_addr, rd_data);
    end
    tick();
    b_valid = 0;
    n_vec++;
    if ({w_en, rd_addr, rd_data} !== {1'b1, 4'd4, 32'hB4}) begin
      n_err++; $display("FAIL b2b_cycle4: w_en=%b rd_addr=%0d rd_data=%h want 1/4/b4",
                        w_en, rd_addr, rd_data);
    end
    tick();
    n_vec++;
    if ({w_en, busy_vec, wb_err} !== {1'b0, 16'h0000, 1'b0}) begin
      n_err++; $display("FAIL b2b_end: w_en=%b busy=%h err=%b want 0/0000/0", w_en, busy_vec, wb_err);
    end
  endtask

  task automatic test_waw();
    reserve(4'd7);
    set_en = 1; set_addr = 7;
    #1;
    n_vec++;
    if (set_ok !== 1'b0) begin
      n_err++; $display("FAIL waw_deny: got %b want 0", set_ok);
    end
    set_en = 0;
    a_valid = 1; a_addr = 7; a_data = 32'h77;
    tick();
    a_valid = 0;
    set_en = 1; set_addr = 7;
    #1;
    n_vec++;
    if ({w_en, rd_addr, set_ok} !== {1'b1, 4'd7, 1'b1}) begin
      n_err++; $display("FAIL waw_same_cycle: w_en=%b rd_addr=%0d set_ok=%b want 1/7/1",
                        w_en, rd_addr, set_ok);
    end
    tick();
    set_en = 0;
    n_vec++;
    if ({busy_vec, wb_err} !== {16'h0080, 1'b0}) begin
      n_err++; $display("FAIL waw_set_wins: busy=%h err=%b want 0080/0", busy_vec, wb_err);
    end
    // Retire the second reservation
    b_valid = 1; b_addr = 7; b_data = 32'h78;
    tick();
    b_valid = 0;
    tick();
    n_vec++;
    if ({busy_vec, wb_err} !== {16'h0000, 1'b0}) begin
      n_err++; $display("FAIL waw_retire: busy=%h err=%b want 0000/0", busy_vec, wb_err);
    end
  endtask

  task automatic test_unreserved();
    b_valid = 1; b_addr = 9; b_data = 32'h99;
    #1;
    n_vec++;
    if (b_ready !== 1'b1) begin
      n_err++; $display("FAIL unres_ready: got %b want 1", b_ready);
    end
    tick();
    b_valid = 0;
    n_vec++;
    if ({w_en, rd_addr, rd_data, wb_err} !== {1'b1, 4'd9, 32'h99, 1'b0}) begin
      n_err++; $display("FAIL unres_write: w_en=%b rd_addr=%0d rd_data=%h err=%b want 1/9/99/0",
                        w_en, rd_addr, rd_data, wb_err);
    end
    tick();
    n_vec++;
    if ({wb_err, busy_vec} !== {1'b1, 16'h0000}) begin
      n_err++; $display("FAIL unres_err: err=%b busy=%h want 1/0000", wb_err, busy_vec);
    end
    tick();
    tick();
    n_vec++;
    if (wb_err !== 1'b1) begin
      n_err++; $display("FAIL unres_sticky: got %b want 1", wb_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int r = 4; r <= 7; r++) reserve(4'(r));
    n_vec++;
    if (busy_vec !== 16'h00F0) begin
      n_err++; $display("FAIL rstmid_pre: got %h want 00f0", busy_vec);
    end
    rst = 1;
    a_valid = 1; a_addr = 4; a_data = 32'h44;
    #1;
    n_vec++;
    if (a_ready !== 1'b0) begin
      n_err++; $display("FAIL rstmid_ready: got %b want 0", a_ready);
    end
    tick();
    rst = 0;
    a_valid = 0;
    n_vec++;
    if ({busy_vec, w_en, rd_addr, rd_data} !== {16'h0000, 1'b0, 4'd0, 32'h0}) begin
      n_err++; $display("FAIL rstmid_after: busy=%h w_en=%b rd_addr=%0d rd_data=%h want 0000/0/0/0",
                        busy_vec, w_en, rd_addr, rd_data);
    end
    tick();
    n_vec++;
    if ({w_en, wb_err} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_nowrite: w_en=%b err=%b want 0/0", w_en, wb_err);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_waw();
    test_unreserved();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_wb_sched.md
Name: reg_wb_sched

Overview:
- Write-back scheduler and register scoreboard for the 16x32 register file with ports rn/rm read, rd write, and w_en.
- Arbitrates two write-back requesters onto the single rd write port: A = ALU, B = load/memory.
- Tracks pending (reserved) destination registers so issue logic can detect RAW/WAW hazards on rn/rm.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, data width of the write port.
- ADDR_W, 4, register address width; the number of registers is 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A has a write pending.
- a_addr  input  ADDR_W  requester A destination.
- a_data  input  DATA_W  requester A data.
- a_ready  output  1  requester A granted this cycle.
- b_valid  input  1  requester B has a write pending.
- b_addr  input  ADDR_W  requester B destination.
- b_data  input  DATA_W  requester B data.
- b_ready  output  1  requester B granted this cycle.
- w_en  output  1  register file write enable.
- rd_addr  output  ADDR_W  register file write address.
- rd_data  output  DATA_W  register file write data.
- set_en  input  1  issue stage requests a reservation of set_addr.
- set_addr  input  ADDR_W  register to reserve.
- set_ok  output  1  reservation accepted this cycle.
- rn_addr  input  ADDR_W  hazard query address 1.
- rm_addr  input  ADDR_W  hazard query address 2.
- rn_busy  output  1  rn_addr has a pending write.
- rm_busy  output  1  rm_addr has a pending write.
- busy_vec  output  2**ADDR_W  scoreboard, bit i set = register i pending.
- wb_err  output  1  sticky error: a write committed to a register that was not reserved.

Behaviour:
- Reset (rst=1 at posedge): w_en=0, rd_addr=0, rd_data=0, busy_vec=0, wb_err=0, priority pointer favours A. Reset overrides every other event in that cycle. Any grant in that cycle is discarded (no write issued), and requesters see a_ready/b_ready=0 while rst=1.
- Handshake: a transfer occurs when valid and ready are both 1 at a posedge. Requesters hold addr/data stable while valid=1 and ready=0. ready depends combinationally on valid and the priority pointer, never on data.
- Arbitration (combinational grant):
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the pointer side.
  - After any grant, the pointer moves to the other side (round-robin).
  - With neither valid, the pointer holds.
- Write port, 1-cycle latency, registered:
  - At a posedge with a grant: w_en<=1, and rd_addr/rd_data <= granted addr/data.
  - At a posedge without a grant: w_en<=0, and rd_addr/rd_data hold their values.
  - The register file performs the write at the next posedge. Sustained throughput is 1 write per cycle.
- Scoreboard:
  - Commit = posedge with w_en=1. At commit, busy[rd_addr] is cleared.
  - If busy[rd_addr] was 0 at commit, wb_err<=1 (sticky until rst).
  - set_ok = set_en & (~busy[set_addr] | (w_en & rd_addr==set_addr)). This denies WAW reservation unless the same register commits this cycle.
  - At a posedge with set_ok=1: busy[set_addr]<=1.
  - Set and commit to the same address in the same cycle: set wins, the bit ends at 1, and wb_err is not raised if the bit was 1 before.
  - Set and commit to different addresses: both take effect.
- Queries: rn_busy=busy_vec[rn_addr] and rm_busy=busy_vec[rm_addr], combinational from registered busy_vec. A register reads not-busy starting the cycle after its commit edge, which is when the register file holds the new data.
- Address wrap: all addresses are ADDR_W bits, with no out-of-range case. Register 0 is treated like any other register.

Test Plan:
- Reset, then idle 3 cycles -> w_en=0, rd_addr=0, rd_data=0, busy_vec=0, wb_err=0, a_ready=b_ready=0.
- Reserve r5 (set_en=1, set_addr=5) -> set_ok=1, busy_vec=0x0020, and a query on rn_addr=5 gives rn_busy=1. Next, a_valid with addr 5, data 0xDEADBEEF: a_ready=1; the next cycle gives w_en=1, rd_addr=5, rd_data=0xDEADBEEF. The cycle after that gives busy_vec=0, wb_err=0.
- Reserve r1–r4, then hold a_valid and b_valid for 4 cycles (A addr 1 then 3, B addr 2 then 4) -> grants go A,B,A,B; rd_addr sequence 1,2,3,4 on consecutive cycles with w_en=1; busy_vec ends at 0.
- With r7 busy, set_en addr 7 with no commit -> set_ok=0. Same request in the cycle where w_en=1, rd_addr=7 -> set_ok=1 and busy[7] remains 1.
- b_valid addr 9 with r9 never reserved -> the write still reaches the register file, and wb_err=1 after the commit edge and stays 1.
- With busy_vec=0x00F0, assert rst while a_valid=1 -> busy_vec=0, w_en=0 on the next cycle, and no write is issued from the grant in the reset cycle.
